// File: rtl/register_file_32_if.sv
// register_file_32_if: write/read bus of the 32x32 register file.
// The register file drives rdata1/rdata2/nz_count; the master drives the rest.
interface register_file_32_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [WIDTH-1:0]  rdata1;
   logic [WIDTH-1:0]  rdata2;
   logic [ADDR_W:0]   nz_count;

   modport master (
      output we, waddr, wdata, raddr1, raddr2,
      input  rdata1, rdata2, nz_count
   );

   modport slave (
      input  we, waddr, wdata, raddr1, raddr2,
      output rdata1, rdata2, nz_count
   );
endinterface

// File: rtl/register_file_32.sv
// register_file_32: 32-entry x 32-bit register file, one synchronous write
// port, two combinational read ports, entry 0 hardwired to zero, registered
// count of non-zero entries, asynchronous active-high reset R.
// Optional macro REGFILE_BYPASS_EN adds a write-through bypass on both reads.
module register_file_32 #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input logic               clk,
   input logic               R,
   register_file_32_if.slave bus
);
   localparam int unsigned CNT_W = ADDR_W + 1;

   // Reject inconsistent geometry at elaboration.
   if ((DEPTH != (32'd1 << ADDR_W)) || (DEPTH < 2)) begin : g_bad_cfg
      $fatal(1, "register_file_32: DEPTH must equal 2**ADDR_W and be >= 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] nz_count_q;
   logic [CNT_W-1:0] nz_count_d;

   logic             wr_hit;
   logic             old_zero;
   logic             new_zero;

   // Next storage state and non-zero count from the write port.
   always_comb begin
      mem_d      = mem_q;
      nz_count_d = nz_count_q;
      wr_hit     = bus.we && (bus.waddr != '0);
      old_zero   = (mem_q[bus.waddr] == '0);
      new_zero   = (bus.wdata == '0);
      if (wr_hit) begin
         mem_d[bus.waddr] = bus.wdata;
         if (old_zero && !new_zero) begin
            nz_count_d = nz_count_q + CNT_W'(1);
         end else if (!old_zero && new_zero) begin
            nz_count_d = nz_count_q - CNT_W'(1);
         end
      end
      mem_d[0] = '0;
   end

   // Storage and count registers; R clears everything without a clock.
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         mem_q      <= '{default: '0};
         nz_count_q <= '0;
      end else begin
         mem_q      <= mem_d;
         nz_count_q <= nz_count_d;
      end
   end

   // Combinational read ports; address 0 always reads zero.
   always_comb begin
      bus.rdata1 = (bus.raddr1 == '0) ? '0 : mem_q[bus.raddr1];
      bus.rdata2 = (bus.raddr2 == '0) ? '0 : mem_q[bus.raddr2];
`ifdef REGFILE_BYPASS_EN
      if (!R && wr_hit && (bus.raddr1 == bus.waddr)) begin
         bus.rdata1 = bus.wdata;
      end
      if (!R && wr_hit && (bus.raddr2 == bus.waddr)) begin
         bus.rdata2 = bus.wdata;
      end
`else
      // Collisions show the stored value until the write edge.
`endif
      bus.nz_count = nz_count_q;
   end
endmodule

// File: tb/tb_register_file_32.sv
// tb_register_file_32: directed plus randomized checks of register_file_32
// against an array model of the register contents.
module tb_register_file_32;
   logic clk;
   logic r_rst;
   logic cmp_en;
   int   checks;
   int   errors;

   logic [31:0] model [32];

   register_file_32_if #(.WIDTH(32), .ADDR_W(5)) bus ();

   register_file_32 #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
      .clk (clk),
      .R   (r_rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference contents: cleared by reset level, written on rising edges.
   always @(posedge clk or posedge r_rst) begin
      if (r_rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (bus.we && bus.waddr != 5'd0) begin
         model[bus.waddr] = bus.wdata;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (bus.we && !r_rst && bus.waddr == a) return bus.wdata;
`endif
      return model[a];
   endfunction

   function automatic logic [31:0] exp_nz();
      int n;
      n = 0;
      for (int i = 1; i < 32; i++) if (model[i] != 32'h0) n++;
      return 32'(n);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("rdata1", bus.rdata1, exp_rd(bus.raddr1));
         check("rdata2", bus.rdata2, exp_rd(bus.raddr2));
         check("nz_count", 32'(bus.nz_count), exp_nz());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.we    = 1'b1;
      bus.waddr = a;
      bus.wdata = d;
      step();
      bus.we    = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      cmp_en      = 1'b0;
      r_rst       = 1'b1;
      bus.we      = 1'b0;
      bus.waddr   = 5'd0;
      bus.wdata   = 32'h0;
      bus.raddr1  = 5'd0;
      bus.raddr2  = 5'd0;
      step();
      step();
      bus.raddr1 = 5'd9;
      bus.raddr2 = 5'd17;
      #1;
      check("reset_rd1", bus.rdata1, 32'h0);
      check("reset_rd2", bus.rdata2, 32'h0);
      check("reset_nz", 32'(bus.nz_count), 32'h0);
      r_rst  = 1'b0;
      cmp_en = 1'b1;
      step();

      // Reset mid-cycle clears storage immediately.
      wr(5'd5, 32'hDEADBEEF);
      bus.raddr1 = 5'd5;
      #1;
      check("wr5", bus.rdata1, 32'hDEADBEEF);
      check("wr5_nz", 32'(bus.nz_count), 32'h1);
      #1;
      r_rst = 1'b1;
      #1;
      check("async_rst_rd", bus.rdata1, 32'h0);
      check("async_rst_nz", 32'(bus.nz_count), 32'h0);
      step();
      r_rst = 1'b0;
      step();

      // Entry 0 ignores writes.
      bus.raddr1 = 5'd0;
      wr(5'd0, 32'hFFFFFFFF);
      #1;
      check("entry0", bus.rdata1, 32'h0);
      check("entry0_nz", 32'(bus.nz_count), 32'h0);

      // Dual-port reads, including the same entry on both ports.
      wr(5'd3, 32'hAAAAAAAA);
      wr(5'd31, 32'h1F2E3D4C);
      bus.raddr1 = 5'd3;
      bus.raddr2 = 5'd31;
      #1;
      check("dual_rd1", bus.rdata1, 32'hAAAAAAAA);
      check("dual_rd2", bus.rdata2, 32'h1F2E3D4C);
      bus.raddr1 = 5'd31;
      #1;
      check("same_rd1", bus.rdata1, 32'h1F2E3D4C);
      check("same_rd2", bus.rdata2, 32'h1F2E3D4C);

      // A write with R high has no effect.
      r_rst     = 1'b1;
      bus.we    = 1'b1;
      bus.waddr = 5'd7;
      bus.wdata = 32'h1;
      step();
      bus.we    = 1'b0;
      r_rst     = 1'b0;
      bus.raddr1 = 5'd7;
      #1;
      check("rst_wr7", bus.rdata1, 32'h0);
      check("rst_wr7_nz", 32'(bus.nz_count), 32'h0);
      step();

      // Non-zero count tracking.
      wr(5'd1, 32'h1);
      wr(5'd2, 32'h1);
      wr(5'd3, 32'h1);
      check("nz_3", 32'(bus.nz_count), 32'h3);
      wr(5'd2, 32'h5);
      check("nz_rewrite", 32'(bus.nz_count), 32'h3);
      wr(5'd1, 32'h0);
      check("nz_clear", 32'(bus.nz_count), 32'h2);

      // Read/write collision on entry 4.
      wr(5'd4, 32'h11);
      bus.raddr1 = 5'd4;
      bus.we     = 1'b1;
      bus.waddr  = 5'd4;
      bus.wdata  = 32'h22;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("coll_before", bus.rdata1, 32'h22);
`else
      check("coll_before", bus.rdata1, 32'h11);
`endif
      step();
      bus.we = 1'b0;
      #1;
      check("coll_after", bus.rdata1, 32'h22);

      // Randomized traffic with occasional reset pulses.
      for (int n = 0; n < 3000; n++) begin
         r_rst      = ($urandom_range(0, 99) == 0);
         bus.we     = ($urandom_range(0, 2) != 0);
         bus.waddr  = 5'($urandom_range(0, 31));
         bus.wdata  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
         bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
         bus.raddr2 = 5'($urandom_range(0, 31));
         step();
      end
      r_rst  = 1'b0;
      bus.we = 1'b0;
      step();
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
